// File: rtl/vseq_pkg.sv
// ----------------------------------------------------------------------------
// vseq_pkg
// Shared types and helpers for the vector memory sequencer.
//   vseq_state_t   : sequencer FSM states
//   clog2()        : index width for an element count
//   VSEQ_*_DEF     : default vector geometry
// ----------------------------------------------------------------------------
package vseq_pkg;

    localparam int VSEQ_ELEMS_DEF = 16;
    localparam int VSEQ_EW_DEF    = 16;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } vseq_state_t;

    // Number of bits needed to index n items (n >= 2).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vseq_rd_tracker.sv
// ----------------------------------------------------------------------------
// vseq_rd_tracker
// Shift pipe of {valid, element index} matching the RAM read latency, so each
// read result can be written to the right element slot when it arrives.
// Ports:
//   clk, rst            : core clock, asynchronous active-low reset
//   push_valid/push_idx : read issued this cycle and its element index
//   retire_valid/idx    : ram_q this cycle belongs to element retire_idx
//   empty               : nothing is in flight beyond the entry retiring now
// ----------------------------------------------------------------------------
module vseq_rd_tracker #(
    parameter int RD_LAT = 1,
    parameter int IW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_valid,
    input  logic [IW-1:0] push_idx,
    output logic          retire_valid,
    output logic [IW-1:0] retire_idx,
    output logic          empty
);

    // Stage 0 is the newest entry, stage RD_LAT-1 lines up with ram_q.
    logic [RD_LAT-1:0] vld_p;
    logic [IW-1:0]     idx_p [RD_LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= push_valid;
            for (int s = 1; s < RD_LAT; s++) begin
                vld_p[s] <= vld_p[s-1];
            end
        end
    end

    // Indices are qualified by vld_p, so they need no reset.
    always_ff @(posedge clk) begin
        idx_p[0] <= push_idx;
        for (int s = 1; s < RD_LAT; s++) begin
            idx_p[s] <= idx_p[s-1];
        end
    end

    assign retire_valid = vld_p[RD_LAT-1];
    assign retire_idx   = idx_p[RD_LAT-1];

    // "empty" looks past the retiring stage so the parent can leave DRAIN in
    // the same cycle the final element is captured.
    generate
        if (RD_LAT == 1) begin : g_single
            assign empty = 1'b1;
        end else begin : g_multi
            assign empty = ~|vld_p[RD_LAT-2:0];
        end
    endgenerate

endmodule

// File: rtl/vec_mem_sequencer.sv
// ----------------------------------------------------------------------------
// vec_mem_sequencer
// MEM-stage sequencer for a single-port data RAM. A vector load/store is
// expanded into ELEMS consecutive element accesses; a scalar access is a
// single element. The pipeline is stalled while the sequencer owns the RAM,
// and a gathered load vector plus its destination register are returned.
//
// Optional build macro: VSEQ_PERF_CNT_EN adds perf_busy / perf_xfers.
//
// Ports:
//   clk, rst             : core clock, asynchronous active-low reset
//   req_valid            : request, held by the requester until done
//   req_write/req_vector : store/load, vector/scalar
//   req_addr             : base address
//   req_wvec/req_wscalar : store data (element i at [i*EW+:EW])
//   req_rd               : destination register of a load
//   ram_addr/wren/wdata  : RAM command, ram_q : RAM read data
//   stall                : freeze IF..EX/MEM registers
//   done                 : one-cycle completion pulse
//   rdata/rd_out         : last completed load vector and its register
//   perf_busy/perf_xfers : (VSEQ_PERF_CNT_EN) stall cycles / done pulses
// ----------------------------------------------------------------------------
module vec_mem_sequencer
    import vseq_pkg::*;
#(
    parameter int ELEMS  = VSEQ_ELEMS_DEF,
    parameter int EW     = VSEQ_EW_DEF,
    parameter int AW     = 19,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic                req_vector,
    input  logic [AW-1:0]       req_addr,
    input  logic [ELEMS*EW-1:0] req_wvec,
    input  logic [EW-1:0]       req_wscalar,
    input  logic [4:0]          req_rd,
    output logic [AW-1:0]       ram_addr,
    output logic                ram_wren,
    output logic [EW-1:0]       ram_wdata,
    input  logic [EW-1:0]       ram_q,
    output logic                stall,
    output logic                done,
    output logic [ELEMS*EW-1:0] rdata,
    output logic [4:0]          rd_out
`ifdef VSEQ_PERF_CNT_EN
    ,
    output logic [31:0]         perf_busy,
    output logic [31:0]         perf_xfers
`endif
);

    localparam int            IW       = clog2(ELEMS);
    localparam logic [IW-1:0] LAST_IDX = IW'(ELEMS - 1);

    vseq_state_t state, state_nxt;

    logic [IW-1:0]       idx;
    logic [AW-1:0]       addr_hold;

    logic [AW-1:0]       base_q;
    logic [ELEMS*EW-1:0] wvec_q;
    logic [EW-1:0]       wscalar_q;
    logic [4:0]          rd_q;
    logic                vec_q;

    logic                accept;
    logic                push_valid;
    logic                last_elem;
    logic [AW-1:0]       elem_addr;
    logic [EW-1:0]       wr_elem;

    logic                ret_valid;
    logic [IW-1:0]       ret_idx;
    logic                trk_empty;

    // Element address wraps naturally at AW bits.
    assign elem_addr = base_q + AW'(idx);
    assign last_elem = vec_q ? (idx == LAST_IDX) : 1'b1;
    assign wr_elem   = vec_q ? wvec_q[idx*EW +: EW] : wscalar_q;

    // ---- next state / outputs ----
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        push_valid = 1'b0;
        stall      = 1'b0;
        done       = 1'b0;
        ram_wren   = 1'b0;
        ram_wdata  = '0;
        ram_addr   = addr_hold;
        unique case (state)
            IDLE: begin
                // Gated by rst so stall reads 0 while reset is asserted.
                stall = rst & req_valid;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = req_write ? WRITE : READ;
                end
            end
            WRITE: begin
                stall     = 1'b1;
                ram_wren  = 1'b1;
                ram_addr  = elem_addr;
                ram_wdata = wr_elem;
                if (last_elem) state_nxt = DONE;
            end
            READ: begin
                stall      = 1'b1;
                ram_addr   = elem_addr;
                push_valid = 1'b1;
                if (last_elem) state_nxt = DRAIN;
            end
            DRAIN: begin
                stall = 1'b1;
                if (trk_empty) state_nxt = DONE;
            end
            DONE: begin
                // The request is still held here; returning to IDLE without
                // looking at req_valid prevents a retrigger.
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- control registers ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            addr_hold <= '0;
            rd_out    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                idx <= '0;
            end else if (state == WRITE || state == READ) begin
                idx       <= last_elem ? '0 : idx + 1'b1;
                addr_hold <= elem_addr;
            end
            // Only loads pass through DRAIN; publish rd with the final element.
            if (state == DRAIN && trk_empty) begin
                rd_out <= rd_q;
            end
        end
    end

    // ---- request latch (datapath, qualified by state) ----
    always_ff @(posedge clk) begin
        if (accept) begin
            base_q    <= req_addr;
            wvec_q    <= req_wvec;
            wscalar_q <= req_wscalar;
            rd_q      <= req_rd;
            vec_q     <= req_vector;
        end
    end

    vseq_rd_tracker #(
        .RD_LAT (RD_LAT),
        .IW     (IW)
    ) u_rd_tracker (
        .clk          (clk),
        .rst          (rst),
        .push_valid   (push_valid),
        .push_idx     (idx),
        .retire_valid (ret_valid),
        .retire_idx   (ret_idx),
        .empty        (trk_empty)
    );

    // ---- read capture ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (ret_valid) begin
            if (vec_q) begin
                rdata[ret_idx*EW +: EW] <= ram_q;
            end else begin
                // Scalar load: element 0 only, upper elements cleared.
                rdata <= (ELEMS*EW)'(ram_q);
            end
        end
    end

`ifdef VSEQ_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    // ---- performance counters ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_busy  <= '0;
            perf_xfers <= '0;
        end else begin
            if (stall) perf_busy  <= sat_inc(perf_busy);
            if (done)  perf_xfers <= sat_inc(perf_xfers);
        end
    end
`endif

endmodule

// File: tb/tb_vec_mem_sequencer.sv
module tb_vec_mem_sequencer;

    localparam int ELEMS  = 16;
    localparam int EW     = 16;
    localparam int AW     = 19;
    localparam int RD_LAT = 1;
    localparam int VW     = ELEMS * EW;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_write = 1'b0;
    logic              req_vector = 1'b0;
    logic [AW-1:0]     req_addr = '0;
    logic [VW-1:0]     req_wvec = '0;
    logic [EW-1:0]     req_wscalar = '0;
    logic [4:0]        req_rd = '0;
    logic [AW-1:0]     ram_addr;
    logic              ram_wren;
    logic [EW-1:0]     ram_wdata;
    logic [EW-1:0]     ram_q;
    logic              stall;
    logic              done;
    logic [VW-1:0]     rdata;
    logic [4:0]        rd_out;
`ifdef VSEQ_PERF_CNT_EN
    logic [31:0]       perf_busy;
    logic [31:0]       perf_xfers;
`endif

    vec_mem_sequencer #(
        .ELEMS  (ELEMS),
        .EW     (EW),
        .AW     (AW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_vector  (req_vector),
        .req_addr    (req_addr),
        .req_wvec    (req_wvec),
        .req_wscalar (req_wscalar),
        .req_rd      (req_rd),
        .ram_addr    (ram_addr),
        .ram_wren    (ram_wren),
        .ram_wdata   (ram_wdata),
        .ram_q       (ram_q),
        .stall       (stall),
        .done        (done),
        .rdata       (rdata),
        .rd_out      (rd_out)
`ifdef VSEQ_PERF_CNT_EN
        ,
        .perf_busy   (perf_busy),
        .perf_xfers  (perf_xfers)
`endif
    );

    always #5 clk = ~clk;

    // Single-port RAM model, one cycle read latency, plus a backdoor write port
    // used only while the sequencer is idle.
    logic [EW-1:0] mem [0:(1<<AW)-1];
    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_a = '0;
    logic [EW-1:0] pl_d = '0;

    always @(posedge clk) begin
        if (pl_we) mem[pl_a] <= pl_d;
        else if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    typedef struct {
        bit            wr;
        bit            vec;
        logic [AW-1:0] base;
        logic [4:0]    rd;
        logic [EW-1:0] dbase;
        int            exp_lat;
    } vec_t;

    vec_t          tbl [6];
    int            n_vec = 0;
    int            n_err = 0;
    int            n_done = 0;
    logic [VW-1:0] exp_rdata = '0;
    logic [4:0]    exp_rd = '0;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic preload(input vec_t v);
        int cnt;
        cnt = v.vec ? ELEMS : 1;
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            pl_we = 1'b1;
            pl_a  = v.base + AW'(i);
            pl_d  = v.dbase + EW'(i);
        end
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic drive_req(input vec_t v);
        req_write   = v.wr;
        req_vector  = v.vec;
        req_addr    = v.base;
        req_rd      = v.rd;
        req_wscalar = v.vec ? 16'hDEAD : v.dbase;
        for (int i = 0; i < ELEMS; i++) begin
            req_wvec[i*EW +: EW] = v.vec ? v.dbase + EW'(i) : 16'hF000 + EW'(i);
        end
        req_valid = 1'b1;
    endtask

    // Issue one request, watch it to completion and check everything it did.
    task automatic run_txn(input vec_t v, input string tag);
        int            nw;
        int            lat;
        int            exp_nw;
        bit            gap;
        logic [AW-1:0] wa [ELEMS];
        logic [EW-1:0] wd [ELEMS];
        logic [AW-1:0] ea;

        if (!v.wr) preload(v);
        @(negedge clk);
        drive_req(v);
        #1;
        chk({tag, " idle stall"}, VW'(stall), VW'(1));
        nw  = 0;
        lat = 0;
        gap = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (ram_wren) begin
                if (nw < ELEMS) begin
                    wa[nw] = ram_addr;
                    wd[nw] = ram_wdata;
                end
                nw++;
            end
            if (done) begin
                lat = k;
                break;
            end
            if (!stall) gap = 1'b1;
        end
        if (lat != 0) n_done++;
        chk({tag, " latency"}, VW'(lat), VW'(v.exp_lat));
        chk({tag, " stall in done"}, VW'(stall), VW'(0));
        chk({tag, " stall gap"}, VW'(gap), VW'(0));
        req_valid = 1'b0;

        exp_nw = v.wr ? (v.vec ? ELEMS : 1) : 0;
        chk({tag, " write count"}, VW'(nw), VW'(exp_nw));
        for (int j = 0; j < exp_nw && j < nw; j++) begin
            ea = v.base + AW'(j);
            chk($sformatf("%s waddr[%0d]", tag, j), VW'(wa[j]), VW'(ea));
            chk($sformatf("%s wdata[%0d]", tag, j), VW'(wd[j]), VW'(v.dbase + EW'(j)));
        end

        if (!v.wr) begin
            exp_rd = v.rd;
            if (v.vec) begin
                for (int i = 0; i < ELEMS; i++) exp_rdata[i*EW +: EW] = v.dbase + EW'(i);
            end else begin
                exp_rdata = VW'(v.dbase);
            end
        end

        // Cycle after done: back in IDLE, DONE-cycle request not accepted.
        @(negedge clk);
        chk({tag, " post-done stall/wren/done"}, VW'({stall, ram_wren, done}), VW'(0));
        ea = v.base + AW'(v.vec ? ELEMS - 1 : 0);
        chk({tag, " addr hold"}, VW'(ram_addr), VW'(ea));
        chk({tag, " rdata"}, rdata, exp_rdata);
        chk({tag, " rd_out"}, VW'(rd_out), VW'(exp_rd));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t s1, s2, vs, ld;
        int   k;

        //          wr    vec   base       rd     dbase     lat
        tbl[0] = '{1'b1, 1'b1, 19'h00100, 5'd0,  16'h1000, 17};
        tbl[1] = '{1'b0, 1'b1, 19'h00200, 5'd5,  16'hA000, 18};
        tbl[2] = '{1'b0, 1'b0, 19'h00010, 5'd9,  16'h1234, 3};
        tbl[3] = '{1'b1, 1'b0, 19'h00011, 5'd0,  16'hBEEF, 2};
        tbl[4] = '{1'b1, 1'b1, 19'h7FFF8, 5'd0,  16'h5500, 17};
        tbl[5] = '{1'b0, 1'b1, 19'h7FFFC, 5'd31, 16'hC000, 18};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset ctl", VW'({ram_wren, stall, done}), VW'(0));
        chk("reset ram_addr", VW'(ram_addr), VW'(0));
        chk("reset ram_wdata", VW'(ram_wdata), VW'(0));
        chk("reset rdata", rdata, '0);
        chk("reset rd_out", VW'(rd_out), VW'(0));
        rst = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            run_txn(tbl[t], $sformatf("vec%0d", t));
        end

        // Request held through done, next request accepted only in a later IDLE.
        s1 = '{1'b1, 1'b0, 19'h00030, 5'd0, 16'h1111, 2};
        s2 = '{1'b1, 1'b0, 19'h00031, 5'd0, 16'h2222, 2};
        @(negedge clk);
        drive_req(s1);
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ram_wren) k++;
            if (done) break;
        end
        chk("held s1 writes", VW'(k), VW'(1));
        chk("held s1 done", VW'(done), VW'(1));
        drive_req(s2);
        @(negedge clk);
        chk("held idle stall/wren/done", VW'({stall, ram_wren, done}), VW'(3'b100));
        @(negedge clk);
        chk("held s2 write", VW'({ram_wren, ram_addr, ram_wdata}), VW'({1'b1, 19'h00031, 16'h2222}));
        @(negedge clk);
        chk("held s2 done", VW'(done), VW'(1));
        req_valid = 1'b0;
        @(negedge clk);

        // Reset in the middle of a vector store.
        vs = '{1'b1, 1'b1, 19'h00400, 5'd0, 16'h3000, 17};
        drive_req(vs);
        repeat (8) @(negedge clk);
        chk("mid-store element 7", VW'({ram_wren, ram_addr}), VW'({1'b1, 19'h00407}));
`ifdef VSEQ_PERF_CNT_EN
        chk("perf_xfers before reset", VW'(perf_xfers), VW'(n_done + 2));
`endif
        rst = 1'b0;
        #1;
        chk("abort ctl", VW'({ram_wren, stall, done}), VW'(0));
        chk("abort rdata", rdata, '0);
        chk("abort rd_out", VW'(rd_out), VW'(0));
`ifdef VSEQ_PERF_CNT_EN
        chk("abort perf_busy", VW'(perf_busy), VW'(0));
        chk("abort perf_xfers", VW'(perf_xfers), VW'(0));
`endif
        req_valid = 1'b0;
        exp_rdata = '0;
        exp_rd    = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        ld = '{1'b0, 1'b1, 19'h00500, 5'd12, 16'h6000, 18};
        run_txn(ld, "after-reset load");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
- Sequences the single-port data RAM for the MEM stage: expands one vector load/store into ELEMS consecutive element accesses, or performs one scalar access.
- Holds the pipeline stalled while it owns the RAM.
- Returns a gathered vector, plus its destination register, for the MEM/WB register.
- Replaces the separate address, input and output managers and their second memory clock with one FSM on the core clock.

Parameters:
ELEMS, 16, elements per vector (power of two, >=2)
EW, 16, element width in bits
AW, 19, RAM address width
RD_LAT, 1, RAM read latency in cycles from address to q (1..3)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
req_valid  in  1  MEM-stage access request, held by requester until done
req_write  in  1  1=store, 0=load
req_vector  in  1  1=vector (ELEMS accesses), 0=scalar (one access)
req_addr  in  AW  base address (scalar ALU result)
req_wvec  in  ELEMS*EW  store data; element i at bits [i*EW+:EW]
req_wscalar  in  EW  scalar store data
req_rd  in  5  destination register of a load
ram_addr  out  AW  RAM address
ram_wren  out  1  RAM write enable
ram_wdata  out  EW  RAM write data
ram_q  in  EW  RAM read data
stall  out  1  freeze IF..EX/MEM registers
done  out  1  one-cycle completion pulse
rdata  out  ELEMS*EW  gathered load vector
rd_out  out  5  latched destination register

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0, including ram_wren, stall, done, rdata, rd_out and index counters.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: stall = req_valid (combinational).
  - When req_valid=1: latch addr, wvec, wscalar, rd, vector, write.
  - Go to WRITE if write=1, else READ; index i=0.
  - A scalar access is treated as ELEMS=1.
- WRITE, one element per cycle:
  - ram_addr = (base+i) mod 2^AW; ram_wdata = element i (scalar: wscalar); ram_wren=1.
  - After the last element: go to DONE.
- READ, one element per cycle:
  - ram_addr = base+i; ram_wren=0.
  - Issued index is pushed into an RD_LAT-deep valid/index pipe.
  - After the last issue: go to DRAIN.
- DRAIN: stay until the pipe is empty, then go to DONE.
  - Capture: when a pipe entry retires, rdata[idx*EW+:EW] <= ram_q.
  - Scalar load writes element 0 and clears elements 1..ELEMS-1.
- stall=1 throughout WRITE, READ and DRAIN.
- DONE:
  - done=1, stall=0.
  - rdata and rd_out valid and held until the next load completes.
  - Any req_valid this cycle is ignored; the held request must not retrigger.
  - Next state: IDLE.
- Stores do not modify rdata or rd_out.
- Latency from accept to done pulse:
  - Vector store: ELEMS+1 cycles (17 by default).
  - Vector load: ELEMS+RD_LAT+1 cycles (18 by default).
  - Scalar: 2 cycles (store) or RD_LAT+2 cycles (load).
- Address wrap: base+i wraps modulo 2^AW with no error; e.g. base 0x7FFFF gives element 1 at 0x00000.
- ram_addr holds the last driven value when idle; ram_wren is 0 in every state except WRITE.
- Reset mid-operation: immediate abort, ram_wren drops asynchronously, the partial vector is discarded and rdata is cleared.

Optional Feature:
- Macro VSEQ_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_busy (32b) and perf_xfers (32b).
  - perf_busy counts cycles with stall=1; perf_xfers counts done pulses.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package vseq_pkg: state enum vseq_state_t (IDLE, WRITE, READ, DRAIN, DONE), the index-width function clog2(ELEMS), and a localparam for the default ELEMS/EW.
- Sub-module vseq_rd_tracker: RD_LAT-deep shift pipe of {valid, index}. It outputs retire_valid/retire_idx and empty, and resets asynchronously like the parent.

Test Plan:
- Vector store, base 0x00100, element i = 0x1000+i -> 16 cycles ram_wren=1, addresses 0x00100..0x0010F with matching data; done at cycle 17; stall low in the done cycle.
- Vector load, base 0x00200, RAM preloaded with 0xA000+i, req_rd=5 -> rdata element i = 0xA000+i, rd_out=5, done 18 cycles after accept (RD_LAT=1).
- Scalar load at 0x00010 (RAM=0x1234) after a vector load -> rdata element 0=0x1234, elements 1..15=0; scalar store at 0x00011 of 0xBEEF -> exactly one write cycle, done 2 cycles after accept.
- Wrap: vector store at base 0x7FFF8 -> addresses 0x7FFF8..0x7FFFF then 0x00000..0x00007.
- req_valid held high through done -> exactly one transaction; new request accepted only in a later IDLE cycle.
- rst pulled low at element 7 of a vector store -> ram_wren=0, stall=0, done=0 immediately; after release, a new load completes normally; with VSEQ_PERF_CNT_EN the counters read 0 after reset.
